// File: rtl/wb_host_master.sv
// rtl/wb_host_master.sv - single-outstanding pipelined Wishbone master with retry and timeout
module wb_host_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 255,
  parameter int RETRY_MAX  = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_we_i,
  input  logic [ADDR_WIDTH-1:0] cmd_adr_i,
  input  logic [3:0]            cmd_sel_i,
  input  logic [31:0]           cmd_dat_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [31:0]           rsp_dat_o,
  output logic [1:0]            rsp_status_o,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  output logic [3:0]            wb_sel_o,
  output logic [31:0]           wb_dat_o,
  input  logic                  wb_stall_i,
  input  logic                  wb_ack_i,
  input  logic                  wb_err_i,
  input  logic                  wb_rty_i,
  input  logic [31:0]           wb_dat_i
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int RW = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  localparam logic [RW-1:0] RT_LIM  = RW'(RETRY_MAX);

  localparam logic [1:0] ST_OK    = 2'b00;
  localparam logic [1:0] ST_ERR   = 2'b01;
  localparam logic [1:0] ST_TOUT  = 2'b10;
  localparam logic [1:0] ST_RTYEX = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_GAP, S_RESP} state_e;

  state_e                  state_q, state_d;
  logic [TW-1:0]           tmr_q, tmr_d;
  logic [RW-1:0]           retry_q, retry_d;
  logic                    cmd_ready_q, cmd_ready_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [31:0]             rsp_dat_q, rsp_dat_d;
  logic [1:0]              rsp_status_q, rsp_status_d;
  logic                    cyc_q, cyc_d;
  logic                    stb_q, stb_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
  logic [3:0]              sel_q, sel_d;
  logic [31:0]             dat_q, dat_d;

  logic term;
  logic active;
  logic accept;

  assign term   = wb_ack_i | wb_err_i | wb_rty_i;
  assign active = (state_q == S_REQ) || (state_q == S_WAIT);
  assign accept = (state_q == S_IDLE) && cmd_valid_i && cmd_ready_q;

  // State, counters and every output are registered here
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      tmr_q        <= '0;
      retry_q      <= '0;
      cmd_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_dat_q    <= '0;
      rsp_status_q <= '0;
      cyc_q        <= 1'b0;
      stb_q        <= 1'b0;
      we_q         <= 1'b0;
      adr_q        <= '0;
      sel_q        <= '0;
      dat_q        <= '0;
    end else begin
      state_q      <= state_d;
      tmr_q        <= tmr_d;
      retry_q      <= retry_d;
      cmd_ready_q  <= cmd_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_dat_q    <= rsp_dat_d;
      rsp_status_q <= rsp_status_d;
      cyc_q        <= cyc_d;
      stb_q        <= stb_d;
      we_q         <= we_d;
      adr_q        <= adr_d;
      sel_q        <= sel_d;
      dat_q        <= dat_d;
    end
  end

  // Next state plus attempt timer and retry bookkeeping; err > ack > rty, termination beats timeout
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    tmr_d   = tmr_q;
    case (state_q)
      S_IDLE: begin
        retry_d = '0;
        if (accept) state_d = S_REQ;
      end
      S_REQ, S_WAIT: begin
        if (wb_err_i || wb_ack_i) begin
          state_d = S_RESP;
        end else if (wb_rty_i) begin
          if (retry_q < RT_LIM) begin
            retry_d = retry_q + 1'b1;
            state_d = S_GAP;
          end else begin
            state_d = S_RESP;
          end
        end else if (tmr_q == TO_LAST) begin
          state_d = S_RESP;
        end else if (state_q == S_REQ && !wb_stall_i) begin
          state_d = S_WAIT;
        end
      end
      S_GAP:  state_d = S_REQ;
      S_RESP: if (rsp_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_REQ && state_q != S_REQ) begin
      tmr_d = '0;
    end else if (active && tmr_q != TO_LAST) begin
      tmr_d = tmr_q + 1'b1;
    end
  end

  // Output next values decoded from the next state so outputs switch on the same edge as the FSM
  always_comb begin
    cmd_ready_d  = (state_d == S_IDLE);
    cyc_d        = (state_d == S_REQ) || (state_d == S_WAIT);
    stb_d        = (state_d == S_REQ);
    rsp_valid_d  = (state_d == S_RESP);
    rsp_dat_d    = rsp_dat_q;
    rsp_status_d = rsp_status_q;
    we_d         = we_q;
    adr_d        = adr_q;
    sel_d        = sel_q;
    dat_d        = dat_q;
    if (accept) begin
      we_d  = cmd_we_i;
      adr_d = cmd_adr_i;
      sel_d = cmd_sel_i;
      dat_d = cmd_dat_i;
    end
    if (state_d == S_RESP && state_q != S_RESP) begin
      rsp_dat_d = '0;
      if (wb_err_i) begin
        rsp_status_d = ST_ERR;
      end else if (wb_ack_i) begin
        rsp_status_d = ST_OK;
        if (!we_q) rsp_dat_d = wb_dat_i;
      end else if (term) begin
        rsp_status_d = ST_RTYEX;
      end else begin
        rsp_status_d = ST_TOUT;
      end
    end
  end

  assign cmd_ready_o  = cmd_ready_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_dat_o    = rsp_dat_q;
  assign rsp_status_o = rsp_status_q;
  assign wb_cyc_o     = cyc_q;
  assign wb_stb_o     = stb_q;
  assign wb_we_o      = we_q;
  assign wb_adr_o     = adr_q;
  assign wb_sel_o     = sel_q;
  assign wb_dat_o     = dat_q;

endmodule

// File: tb/tb_wb_host_master.sv
// tb/tb_wb_host_master.sv - scoreboard bench for wb_host_master with a behavioural Wishbone slave
module tb_wb_host_master;

  typedef struct packed {
    logic [1:0]  st;
    logic [31:0] dat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic        cmd_we_i = 1'b0;
  logic [31:0] cmd_adr_i = '0;
  logic [3:0]  cmd_sel_i = '0;
  logic [31:0] cmd_dat_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [31:0] rsp_dat_o;
  logic [1:0]  rsp_status_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_o;
  logic        wb_stall_i = 1'b0;
  logic        wb_ack_i = 1'b0;
  logic        wb_err_i = 1'b0;
  logic        wb_rty_i = 1'b0;
  logic [31:0] wb_dat_i = '0;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t exp_q[$];

  // slave behaviour knobs
  bit   stall_mode = 0, silent = 0, err_mode = 0;
  int   resp_lat = 1, n_rty = 0, rty_done = 0, s_cnt = 0;
  int   cyc_num = 0, late_ack_at = -1;
  logic [31:0] mem [16];

  // bus monitor counters
  int   cyc_hi, stb_hi, attempts, gaps;
  bit   in_txn = 0, stb_prev = 0;

  wb_host_master #(.ADDR_WIDTH(32), .TIMEOUT(8), .RETRY_MAX(3)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_adr_i(cmd_adr_i), .cmd_sel_i(cmd_sel_i), .cmd_dat_i(cmd_dat_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_dat_o(rsp_dat_o),
    .rsp_status_o(rsp_status_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
    .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o), .wb_stall_i(wb_stall_i), .wb_ack_i(wb_ack_i),
    .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i), .wb_dat_i(wb_dat_i)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_num++;

  // slave: drives its response mid-cycle so the DUT samples it at the closing edge
  always @(negedge clk) begin
    wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0; wb_dat_i = '0;
    if (!wb_cyc_o) begin
      s_cnt = 0;
      wb_stall_i = 1'b0;
    end else begin
      s_cnt++;
      wb_stall_i = stall_mode && wb_stb_o;
      if (!silent && s_cnt == resp_lat) begin
        if (rty_done < n_rty) begin
          wb_rty_i = 1'b1;
          rty_done++;
        end else begin
          wb_ack_i = 1'b1;
          wb_err_i = err_mode;
          if (!wb_we_o) begin
            wb_dat_i = mem[wb_adr_o[5:2]];
          end else if (!err_mode) begin
            for (int b = 0; b < 4; b++)
              if (wb_sel_o[b]) mem[wb_adr_o[5:2]][8*b +: 8] = wb_dat_o[8*b +: 8];
          end
        end
      end
    end
    if (cyc_num == late_ack_at) wb_ack_i = 1'b1;
  end

  // bus monitor sampled just after each edge
  always @(posedge clk) begin
    #1;
    if (in_txn && !wb_cyc_o && !rsp_valid_o) gaps++;
    if (wb_cyc_o) begin cyc_hi++; in_txn = 1; end
    if (rsp_valid_o) in_txn = 0;
    if (wb_stb_o) stb_hi++;
    if (wb_stb_o && !stb_prev) attempts++;
    stb_prev = wb_stb_o;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic send_cmd(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                          input logic [31:0] dat, output bit ok);
    int n;
    @(negedge clk);
    cmd_valid_i = 1'b1; cmd_we_i = we; cmd_adr_i = adr; cmd_sel_i = sel; cmd_dat_i = dat;
    rty_done = 0;
    n = 0;
    while (!cmd_ready_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    ok = cmd_ready_o;
    cyc_hi = 0; stb_hi = 0; attempts = 0; gaps = 0; in_txn = 0;
    if (!ok) begin
      check("accept_bound", {31'b0, cmd_ready_o}, 32'd1);
      cmd_valid_i = 1'b0;
      return;
    end
    @(negedge clk);
    cmd_valid_i = 1'b0;
    check("ready_low_busy", {31'b0, cmd_ready_o}, 32'd0);
  endtask

  task automatic do_cmd(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                        input logic [31:0] dat, input logic [1:0] st, input logic [31:0] edat,
                        input int hold, input bit late, input int exp_lat);
    bit   ok;
    int   lat;
    exp_t e;
    exp_q.push_back('{st: st, dat: edat});
    send_cmd(we, adr, sel, dat, ok);
    if (!ok) begin
      void'(exp_q.pop_front());
      return;
    end
    lat = 1;
    while (!rsp_valid_o && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid_o) begin
      check("rsp_bound", {31'b0, rsp_valid_o}, 32'd1);
      void'(exp_q.pop_front());
      return;
    end
    if (exp_lat > 0) check("latency", lat, exp_lat);
    check("cyc_low_at_rsp", {31'b0, wb_cyc_o}, 32'd0);
    if (late) late_ack_at = cyc_num + 2;
    e = exp_q[0];
    for (int i = 0; i < hold; i++) begin
      check("hold_valid", {31'b0, rsp_valid_o}, 32'd1);
      check("hold_dat", rsp_dat_o, e.dat);
      check("hold_status", {30'b0, rsp_status_o}, {30'b0, e.st});
      @(negedge clk);
    end
    rsp_ready_i = 1'b1;
    e = exp_q.pop_front();
    check("rsp_dat", rsp_dat_o, e.dat);
    check("rsp_status", {30'b0, rsp_status_o}, {30'b0, e.st});
    @(negedge clk);
    rsp_ready_i = 1'b0;
    check("rsp_drop", {31'b0, rsp_valid_o}, 32'd0);
    check("ready_back", {31'b0, cmd_ready_o}, 32'd1);
    late_ack_at = -1;
  endtask

  initial begin
    bit ok;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", {31'b0, cmd_ready_o}, 32'd0);
    check("rst_rsp_valid", {31'b0, rsp_valid_o}, 32'd0);
    check("rst_wb_ctrl", {29'b0, wb_cyc_o, wb_stb_o, wb_we_o}, 32'd0);
    check("rst_wb_adr", wb_adr_o, 32'd0);
    check("rst_wb_dat", wb_dat_o, 32'd0);
    check("rst_rsp", {rsp_dat_o[29:0], rsp_status_o}, 32'd0);
    rst_i = 1'b0;
    @(negedge clk);
    check("post_rst_ready", {31'b0, cmd_ready_o}, 32'd1);

    // write held off by stall until ack
    stall_mode = 1; resp_lat = 3;
    do_cmd(1'b1, 32'h0, 4'hF, 32'h0000_0712, 2'b00, 32'h0, 0, 0, 4);
    check("stall_stb_cycles", stb_hi, 3);
    check("stall_attempts", attempts, 1);

    // read back with ack in the first request cycle: minimum latency
    stall_mode = 0; resp_lat = 1;
    do_cmd(1'b0, 32'h0, 4'hF, 32'h0, 2'b00, 32'h0000_0712, 0, 0, 2);
    check("min_stb_cycles", stb_hi, 1);

    // partial byte-select write, then read held 5 cycles
    resp_lat = 2;
    do_cmd(1'b1, 32'h4, 4'h5, 32'hAABB_CCDD, 2'b00, 32'h0, 0, 0, 3);
    do_cmd(1'b0, 32'h4, 4'hF, 32'h0, 2'b00, 32'h00BB_00DD, 5, 0, 3);

    // two retries then ack
    n_rty = 2;
    do_cmd(1'b0, 32'h0, 4'hF, 32'h0, 2'b00, 32'h0000_0712, 0, 0, 9);
    check("rty2_attempts", attempts, 3);
    check("rty2_gaps", gaps, 2);
    check("rty2_cyc_cycles", cyc_hi, 6);

    // retries exhausted
    n_rty = 4;
    do_cmd(1'b1, 32'h8, 4'hF, 32'h1234_5678, 2'b11, 32'h0, 0, 0, 0);
    check("rty4_attempts", attempts, 4);
    check("rty4_gaps", gaps, 3);
    check("rty4_no_write", mem[2], 32'h0);
    n_rty = 0;

    // no answer: timeout, late ack ignored
    silent = 1;
    do_cmd(1'b0, 32'h0, 4'hF, 32'h0, 2'b10, 32'h0, 5, 1, 9);
    check("tout_cyc_cycles", cyc_hi, 8);
    check("tout_stb_cycles", stb_hi, 1);
    repeat (3) @(negedge clk);
    check("tout_no_extra_rsp", {31'b0, rsp_valid_o}, 32'd0);
    silent = 0;

    // err and ack together
    err_mode = 1;
    do_cmd(1'b0, 32'h0, 4'hF, 32'h0, 2'b01, 32'h0, 0, 0, 3);
    err_mode = 0;

    // reset while waiting
    silent = 1;
    send_cmd(1'b0, 32'h0, 4'hF, 32'h0, ok);
    if (ok) begin
      @(negedge clk);
      check("wait_state", {30'b0, wb_cyc_o, wb_stb_o}, 32'd2);
      rst_i = 1'b1;
      @(negedge clk);
      check("rst_mid_cyc", {30'b0, wb_cyc_o, wb_stb_o}, 32'd0);
      check("rst_mid_rsp", {31'b0, rsp_valid_o}, 32'd0);
      rst_i = 1'b0;
      @(negedge clk);
      check("rst_mid_ready", {31'b0, cmd_ready_o}, 32'd1);
      repeat (10) @(negedge clk);
      check("rst_mid_no_rsp", {31'b0, rsp_valid_o}, 32'd0);
    end
    silent = 0;

    // normal operation after reset
    resp_lat = 2;
    do_cmd(1'b0, 32'h0, 4'hF, 32'h0, 2'b00, 32'h0000_0712, 0, 0, 3);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wb_host_master.md
# wb_host_master

Single-outstanding Wishbone (pipelined) bus master that sits directly upstream of the generated register blocks. It takes one command at a time from a host-side valid/ready port and issues exactly one Wishbone transaction. It waits for ack/err/rty, retrying on rty and aborting on timeout, then returns data and a status code on a valid/ready response port. It is the only driver of the slave's wb_* inputs.

## Interface
Parameters:
- ADDR_WIDTH, 32: width of cmd_adr_i / wb_adr_o.
- TIMEOUT, 255: max cycles per attempt (from stb assertion to termination); range 2..65535.
- RETRY_MAX, 3: extra attempts allowed after rty; 0 disables retry.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- cmd_valid_i  in  1  host command valid.
- cmd_ready_o  out  1  command accepted when valid & ready.
- cmd_we_i  in  1  1 = write, 0 = read.
- cmd_adr_i  in  ADDR_WIDTH  byte address.
- cmd_sel_i  in  4  byte selects.
- cmd_dat_i  in  32  write data.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  host consumes response.
- rsp_dat_o  out  32  read data. 0 for writes and failures.
- rsp_status_o  out  2  00 ok, 01 err, 10 timeout, 11 retries exhausted.
- wb_cyc_o, wb_stb_o, wb_we_o  out  1  Wishbone controls.
- wb_adr_o  out  ADDR_WIDTH; wb_sel_o  out  4; wb_dat_o  out  32.
- wb_stall_i, wb_ack_i, wb_err_i, wb_rty_i  in  1.
- wb_dat_i  in  32.

## Operation
- FSM states: IDLE, REQ, WAIT, GAP, RESP.
- IDLE:
  - cmd_ready_o=1.
  - On cmd_valid_i, latch we/adr/sel/dat into command registers and go to REQ.
  - Clear retry count.
- REQ:
  - cyc=stb=1; wb_adr/sel/we/dat driven from the latched command.
  - Termination (ack, err or rty) is accepted here even while stall=1. Slaves may hold stall until ack.
  - No termination and stall=0: go to WAIT.
- WAIT: cyc=1, stb=0. Wait for termination.
- Termination priority in one cycle: err > ack > rty.
  - err: status 01, go to RESP.
  - ack: status 00, go to RESP. Capture wb_dat_i into rsp_dat_o if read; 0 if write.
  - rty with retry count < RETRY_MAX: increment count, go to GAP.
  - rty with count == RETRY_MAX: status 11, go to RESP.
- GAP: cyc=stb=0 for exactly one cycle, then REQ.
- Timeout:
  - Counter cleared on each entry to REQ; increments every cycle in REQ/WAIT.
  - If the counter reaches TIMEOUT-1 with no termination that cycle, go to RESP with status 10 and drop cyc/stb.
  - A termination in the same cycle as the timeout wins.
- RESP:
  - rsp_valid_o=1; rsp_dat_o and rsp_status_o stable until rsp_ready_i.
  - On rsp_ready_i, go to IDLE.
- Terminations arriving in IDLE, GAP or RESP (late acks) are ignored.
- Only one transaction in flight; cmd_ready_o is low in every state except IDLE.

## Timing
- Reset values: cmd_ready_o=0 during reset then 1. All of the following are 0: rsp_valid_o, rsp_dat_o, rsp_status_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o. FSM starts in IDLE.
- Reset mid-transaction: cyc/stb deassert at the next edge; no response is produced.
- All outputs are registered; no combinational path from wb_* inputs to any output.
- Accept at edge N: cyc/stb high from cycle N+1.
- Termination sampled at edge M: cyc/stb low and rsp_valid_o high from cycle M+1.
- Minimum command-to-response latency is 2 cycles (ack in the first REQ cycle). The response handshake takes 1 further cycle before the next command can be accepted.
- wb_stb_o is high for at least one cycle per attempt; it drops the cycle after stall=0 is sampled.
- Counter width is clog2(TIMEOUT+1); it never wraps.

## Test plan
- Write adr 0x0, dat 0x00000712, sel 0xF to a register slave that stalls until ack:
  - stb held through stall; ack ends the cycle.
  - Response status 00, dat 0.
  - Slave field01 reads back 0x1.
- Read after that write, with the slave driving field00_i=1 and field02_i=3:
  - rsp_dat_o = 0x00000312, status 00.
- Slave answers rty twice then ack, RETRY_MAX=3:
  - Exactly two 1-cycle GAPs with cyc low.
  - 3 stb assertions total; status 00.
- Slave answers rty four times, RETRY_MAX=3:
  - 4 attempts; status 11; cyc low afterwards.
- Slave never responds, TIMEOUT=8:
  - cyc drops 8 cycles after stb first rose; status 10.
  - A late ack 2 cycles later is ignored; cmd_ready_o=1 once the response is consumed.
- err and ack asserted in the same cycle → status 01.
- rsp_ready_i held low for 5 cycles → rsp_valid_o and rsp_dat_o stable for all 5.
- rst_i asserted while in WAIT → cyc=0 next cycle, no rsp_valid_o, cmd_ready_o=1 after reset.
